update_scheduler: RTL
=====================

UPDATE_SCHEDULER -- requirements
Module: update_scheduler

Interface
REQ-001 SHALL have parameter PLAYER_DIV, default 200000, clk_i cycles per player tick.
REQ-002 SHALL have parameter BULLET_DIV, default 75000, clk_i cycles per bullet tick.
REQ-003 SHALL have parameter SEC_DIV, default 50000000, clk_i cycles per one-second tick.
REQ-004 SHALL have parameter WDOG_CYCLES, default 1024, grant timeout in cycles (used only with REQ-030).
REQ-005 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-006 SHALL have ports: rst_ni  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: blank_i  in  1  display blanking; 1 = object memory may be updated.
REQ-008 SHALL have ports: pause_i  in  1  1 = prescalers hold.
REQ-009 SHALL have ports: done_i  in  1  datapath finished the granted update.
REQ-010 SHALL have ports: grant_o  out  3  one-hot grant: [0] player, [1] bullet, [2] second.
REQ-011 SHALL have ports: busy_o  out  1  grant outstanding.
REQ-012 SHALL have ports: overrun_o  out  3  sticky per-source missed-tick flags.
REQ-013 SHALL have ports: timeout_o  out  1  one-cycle watchdog abort pulse.

Function
REQ-014 SHALL keep one prescaler per source counting 0..DIV-1, wrapping to 0, and raising a tick in the cycle the count equals DIV-1.
REQ-015 SHALL hold all prescaler counts while pause_i=1, with no ticks generated.
REQ-016 SHALL set pending[n] in the cycle after a tick on source n.
REQ-017 SHALL set overrun_o[n] (sticky until reset) when a tick arrives while pending[n] is set and not being cleared that cycle.
REQ-018 SHALL implement FSM with states IDLE and WAIT.
REQ-019 IDLE: if blank_i=1 and any pending bit is set, SHALL select one source round-robin, starting after the last granted source, and enter WAIT.
REQ-020 SHALL register grant_o, asserting exactly one bit in the first WAIT cycle and holding it until done_i=1 is sampled.
REQ-021 SHALL, on done_i=1 in WAIT, clear the granted pending bit, drive grant_o=0 the next cycle, and return to IDLE; at least one IDLE cycle separates grants.
REQ-022 SHALL drive busy_o=1 exactly while in WAIT.
REQ-023 SHALL, when a tick and a done clear on the same source coincide, leave pending set and not flag overrun.
REQ-024 SHALL NOT abort a grant when blank_i falls during WAIT.
REQ-025 SHALL ignore done_i in IDLE.
REQ-026 SHALL require DIV parameters >= 2; counter width SHALL be $clog2(DIV).

Reset
REQ-027 SHALL, while rst_ni=0, asynchronously clear all prescalers, pending bits, and round-robin pointer (next search starts at player), and enter IDLE.
REQ-028 SHALL drive grant_o=0, busy_o=0, overrun_o=0, and timeout_o=0 during reset.
REQ-029 SHALL discard any outstanding grant when reset asserts mid-WAIT; no done_i is expected afterwards.

Configuration
REQ-030 With UPDATE_SCHED_WATCHDOG_EN defined, SHALL count WAIT cycles and, after WDOG_CYCLES cycles without done_i, drop grant_o, clear that pending bit, pulse timeout_o for one cycle, and return to IDLE.
REQ-031 Without UPDATE_SCHED_WATCHDOG_EN, SHALL tie timeout_o to 0 and wait in WAIT indefinitely.

Verification
REQ-032 Bench SHALL cover: PLAYER_DIV=4, blank_i=1, done_i returned 2 cycles after grant -> grant_o=001 every 4 cycles, no overrun.
REQ-033 Bench SHALL cover: all three sources pending, blank_i=1 -> grants in order 001, 010, 100, each separated by at least one idle cycle.
REQ-034 Bench SHALL cover: blank_i=0 held for two BULLET_DIV=3 periods -> overrun_o=010 and one grant once blank_i=1.
REQ-035 Bench SHALL cover: tick coincident with done_i on the same source -> pending stays 1, second grant follows, overrun_o=000.
REQ-036 Bench SHALL cover: WDOG_CYCLES=8 with the macro defined, done_i never asserted -> grant drops after 8 cycles and timeout_o=1 for one cycle; without the macro, grant is held.
REQ-037 Bench SHALL cover: rst_ni=0 asserted mid-WAIT -> grant_o=000 immediately; after release, the first grant serves the player source.

Source files
------------

// File: rtl/update_scheduler.sv
//==============================================================================
// Module   : update_scheduler
// Desc     : Three prescaled update sources (player, bullet, second) granted
//            round-robin into display blanking; optional grant watchdog
//            enabled by defining UPDATE_SCHED_WATCHDOG_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module update_scheduler #(
    parameter int PLAYER_DIV  = 200000,
    parameter int BULLET_DIV  = 75000,
    parameter int SEC_DIV     = 50000000,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       blank_i,
    input  logic       pause_i,
    input  logic       done_i,
    output logic [2:0] grant_o,
    output logic       busy_o,
    output logic [2:0] overrun_o,
    output logic       timeout_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_grant;
    logic [2:0] w_grant_nxt;
    logic [2:0] r_pending;
    logic [2:0] r_overrun;
    logic [1:0] r_last;
    logic [1:0] w_last_nxt;
    logic [2:0] w_tick;
    logic [2:0] w_clr;
    logic [1:0] w_c0;
    logic [1:0] w_c1;
    logic [1:0] w_c2;
    logic [1:0] w_sel;
    logic       w_wdog_expired;

    function automatic logic [1:0] next_src(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Every divider must be at least 2 so the counter has a non-zero width.
    for (genvar gi = 0; gi < 3; gi++) begin : g_presc
        localparam int c_DIV   = (gi == 0) ? PLAYER_DIV : (gi == 1) ? BULLET_DIV : SEC_DIV;
        localparam int c_CNT_W = $clog2(c_DIV);
        localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DIV - 1);

        logic [c_CNT_W-1:0] r_cnt;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt <= '0;
            end else if (!pause_i) begin
                r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
            end
        end

        assign w_tick[gi] = !pause_i && (r_cnt == c_CNT_LAST);
    end

    // Round-robin search order begins with the source after the last grant.
    assign w_c0 = next_src(r_last);
    assign w_c1 = next_src(w_c0);
    assign w_c2 = next_src(w_c1);

    always_comb begin
        w_sel = w_c2;
        if (r_pending[w_c0]) begin
            w_sel = w_c0;
        end else if (r_pending[w_c1]) begin
            w_sel = w_c1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_clr       = '0;
        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                if (blank_i && (|r_pending)) begin
                    w_grant_nxt = 3'b001 << w_sel;
                    w_last_nxt  = w_sel;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Blanking may end mid-grant; only done or the watchdog ends it.
                if (done_i || w_wdog_expired) begin
                    w_clr       = r_grant;
                    w_grant_nxt = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A tick landing on the cycle its pending bit is cleared re-arms it cleanly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_grant   <= '0;
            r_last    <= 2'd2;
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_grant   <= w_grant_nxt;
            r_last    <= w_last_nxt;
            r_pending <= (r_pending & ~w_clr) | w_tick;
            r_overrun <= r_overrun | (w_tick & r_pending & ~w_clr);
        end
    end

`ifdef UPDATE_SCHED_WATCHDOG_EN
    localparam int c_WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_CYCLES - 1);

    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_timeout;

    assign w_wdog_expired = (r_state == S_WAIT) && !done_i && (r_wdog == c_WDOG_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_wdog_expired;
            if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) begin
                r_wdog <= r_wdog + 1'b1;
            end else begin
                r_wdog <= '0;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_wdog_expired = 1'b0;
    // Constant 0: the grant is held until done_i however long it takes.
    assign timeout_o = (WDOG_CYCLES < 0);
`endif

    assign grant_o   = r_grant;
    assign busy_o    = (r_state == S_WAIT);
    assign overrun_o = r_overrun;

endmodule

`default_nettype wire
